// File: rtl/bus_arbiter_xbar.sv
// bus_arbiter_xbar: two-master round-robin arbiter with base/mask decode to NUM_SLAVES slaves,
// one outstanding transaction, decode-miss and response-timeout error responses.
module bus_arbiter_xbar #(
    parameter int                        NUM_SLAVES     = 5,
    parameter logic [32*NUM_SLAVES-1:0]  SLAVE_BASE     = {32'h4000_0000, 32'h3000_0000, 32'h2000_0000,
                                                          32'h1000_0000, 32'h0000_0000},
    parameter logic [32*NUM_SLAVES-1:0]  SLAVE_MASK     = {5{32'hF000_0000}},
    parameter int                        TIMEOUT_CYCLES = 255
) (
    input  logic                         clk_i,
    input  logic                         n_rst_i,
    input  logic                         m0_req_i,
    input  logic [3:0]                   m0_sel_i,
    input  logic [31:0]                  m0_addr_i,
    input  logic                         m0_we_i,
    input  logic [31:0]                  m0_data_i,
    output logic                         m0_gnt_o,
    output logic                         m0_rvalid_o,
    output logic                         m0_err_o,
    output logic [31:0]                  m0_data_o,
    input  logic                         m1_req_i,
    input  logic [3:0]                   m1_sel_i,
    input  logic [31:0]                  m1_addr_i,
    input  logic                         m1_we_i,
    input  logic [31:0]                  m1_data_i,
    output logic                         m1_gnt_o,
    output logic                         m1_rvalid_o,
    output logic                         m1_err_o,
    output logic [31:0]                  m1_data_o,
    output logic [NUM_SLAVES-1:0]        s_req_o,
    output logic [3:0]                   s_sel_o,
    output logic [31:0]                  s_addr_o,
    output logic                         s_we_o,
    output logic [31:0]                  s_data_o,
    input  logic [NUM_SLAVES-1:0]        s_rvalid_i,
    input  logic [32*NUM_SLAVES-1:0]     s_data_i,
    output logic [15:0]                  err_cnt_o
);
    localparam int SW = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] REQ  = 2'd1;
    localparam logic [1:0] WAIT = 2'd2;
    localparam logic [1:0] RESP = 2'd3;

    logic [1:0]    r_state;
    logic          r_last;
    logic          r_idx;
    logic          r_err;
    logic [SW-1:0] r_slv;
    logic [15:0]   r_timer;
    logic [15:0]   r_err_cnt;
    logic [3:0]    r_sel;
    logic [31:0]   r_addr;
    logic          r_we;
    logic [31:0]   r_wdata;
    logic [31:0]   r_mdata [2];

    logic          w_any;
    logic          w_win;
    logic          w_hit;
    logic [SW-1:0] w_slv;
    logic [31:0]   w_addr;
    logic          w_rv;
    logic [31:0]   w_rdata;

    always_comb begin
        w_any  = m0_req_i | m1_req_i;
        w_win  = (m0_req_i & m1_req_i) ? ~r_last : m1_req_i;
        w_addr = w_win ? m1_addr_i : m0_addr_i;
        w_hit  = 1'b0;
        w_slv  = '0;
        // descending scan so the lowest matching slot wins on overlap
        for (int k = NUM_SLAVES - 1; k >= 0; k--) begin
            if ((w_addr & SLAVE_MASK[32*k +: 32]) == SLAVE_BASE[32*k +: 32]) begin
                w_hit = 1'b1;
                w_slv = SW'(k);
            end
        end
        for (int k = 0; k < NUM_SLAVES; k++)
            s_req_o[k] = (r_state == REQ) && (r_slv == SW'(k));
        w_rv    = s_rvalid_i[r_slv];
        w_rdata = s_data_i[32*r_slv +: 32];
    end

    assign m0_gnt_o    = (r_state == IDLE) && w_any && !w_win;
    assign m1_gnt_o    = (r_state == IDLE) && w_win;
    assign m0_rvalid_o = (r_state == RESP) && !r_idx;
    assign m1_rvalid_o = (r_state == RESP) && r_idx;
    assign m0_err_o    = m0_rvalid_o && r_err;
    assign m1_err_o    = m1_rvalid_o && r_err;
    assign m0_data_o   = r_mdata[0];
    assign m1_data_o   = r_mdata[1];
    assign s_sel_o     = r_sel;
    assign s_addr_o    = r_addr;
    assign s_we_o      = r_we;
    assign s_data_o    = r_wdata;
    assign err_cnt_o   = r_err_cnt;

    always_ff @(posedge clk_i or negedge n_rst_i) begin
        if (!n_rst_i) begin
            r_state    <= IDLE;
            r_last     <= 1'b1;
            r_idx      <= 1'b0;
            r_err      <= 1'b0;
            r_slv      <= '0;
            r_timer    <= '0;
            r_err_cnt  <= '0;
            r_sel      <= '0;
            r_addr     <= '0;
            r_we       <= 1'b0;
            r_wdata    <= '0;
            r_mdata[0] <= '0;
            r_mdata[1] <= '0;
        end else begin
            case (r_state)
                IDLE: if (w_any) begin
                    r_last  <= w_win;
                    r_idx   <= w_win;
                    r_sel   <= w_win ? m1_sel_i : m0_sel_i;
                    r_addr  <= w_addr;
                    r_we    <= w_win ? m1_we_i : m0_we_i;
                    r_wdata <= w_win ? m1_data_i : m0_data_i;
                    r_slv   <= w_slv;
                    if (w_hit) begin
                        r_state <= REQ;
                    end else begin
                        r_state        <= RESP;
                        r_err          <= 1'b1;
                        r_mdata[w_win] <= '0;
                    end
                end
                REQ: if (w_rv) begin
                    r_mdata[r_idx] <= w_rdata;
                    r_err          <= 1'b0;
                    r_state        <= RESP;
                end else begin
                    r_timer <= '0;
                    r_state <= WAIT;
                end
                WAIT: if (w_rv) begin
                    r_mdata[r_idx] <= w_rdata;
                    r_err          <= 1'b0;
                    r_state        <= RESP;
                end else if (r_timer == 16'(TIMEOUT_CYCLES - 1)) begin
                    r_mdata[r_idx] <= '0;
                    r_err          <= 1'b1;
                    r_state        <= RESP;
                end else begin
                    r_timer <= r_timer + 16'd1;
                end
                default: begin
                    r_state <= IDLE;
                    if (r_err && r_err_cnt != 16'hFFFF)
                        r_err_cnt <= r_err_cnt + 16'd1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_bus_arbiter_xbar.sv
// tb_bus_arbiter_xbar: directed transactions; expected responses are queued at grant time and
// matched by an independent monitor against each master rvalid, including the arrival cycle.
module tb_bus_arbiter_xbar;
    localparam int NS = 5;

    logic            clk_i = 1'b0;
    logic            n_rst_i;
    logic            m0_req_i, m0_we_i, m0_gnt_o, m0_rvalid_o, m0_err_o;
    logic [3:0]      m0_sel_i;
    logic [31:0]     m0_addr_i, m0_data_i, m0_data_o;
    logic            m1_req_i, m1_we_i, m1_gnt_o, m1_rvalid_o, m1_err_o;
    logic [3:0]      m1_sel_i;
    logic [31:0]     m1_addr_i, m1_data_i, m1_data_o;
    logic [NS-1:0]   s_req_o, s_rvalid_i;
    logic [3:0]      s_sel_o;
    logic [31:0]     s_addr_o, s_data_o;
    logic            s_we_o;
    logic [32*NS-1:0] s_data_i;
    logic [15:0]     err_cnt_o;

    typedef struct {
        bit          m;
        bit          err;
        logic [31:0] data;
        int          cyc;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   lat [NS];
    int   cnt [NS];

    always #5 clk_i = ~clk_i;
    always @(posedge clk_i) cyc <= cyc + 1;

    bus_arbiter_xbar #(.NUM_SLAVES(NS), .TIMEOUT_CYCLES(4)) dut (
        .clk_i(clk_i), .n_rst_i(n_rst_i),
        .m0_req_i(m0_req_i), .m0_sel_i(m0_sel_i), .m0_addr_i(m0_addr_i), .m0_we_i(m0_we_i),
        .m0_data_i(m0_data_i), .m0_gnt_o(m0_gnt_o), .m0_rvalid_o(m0_rvalid_o), .m0_err_o(m0_err_o),
        .m0_data_o(m0_data_o),
        .m1_req_i(m1_req_i), .m1_sel_i(m1_sel_i), .m1_addr_i(m1_addr_i), .m1_we_i(m1_we_i),
        .m1_data_i(m1_data_i), .m1_gnt_o(m1_gnt_o), .m1_rvalid_o(m1_rvalid_o), .m1_err_o(m1_err_o),
        .m1_data_o(m1_data_o),
        .s_req_o(s_req_o), .s_sel_o(s_sel_o), .s_addr_o(s_addr_o), .s_we_o(s_we_o),
        .s_data_o(s_data_o), .s_rvalid_i(s_rvalid_i), .s_data_i(s_data_i), .err_cnt_o(err_cnt_o)
    );

    // slave k raises rvalid lat[k] cycles after its s_req (0 = same cycle, -1 = never)
    always @(negedge clk_i) begin
        for (int k = 0; k < NS; k++) begin
            s_rvalid_i[k] = 1'b0;
            if (s_req_o[k]) cnt[k] = lat[k];
            else if (cnt[k] > 0) cnt[k]--;
            if (cnt[k] == 0) begin
                s_rvalid_i[k] = 1'b1;
                cnt[k] = -1;
            end
        end
    end

    always @(negedge clk_i) begin
        if (n_rst_i && (m0_rvalid_o || m1_rvalid_o)) begin
            checks++;
            if (m0_rvalid_o && m1_rvalid_o) begin
                errors++;
                $display("FAIL rvalid_both at cycle %0d: both masters got rvalid, required one", cyc);
            end else if (q.size() == 0) begin
                errors++;
                $display("FAIL rvalid_unexpected at cycle %0d: m%0d rvalid with nothing outstanding", cyc, m1_rvalid_o);
            end else begin
                mon_e = q.pop_front();
                if (m1_rvalid_o != mon_e.m || (m1_rvalid_o ? m1_err_o : m0_err_o) != mon_e.err ||
                    (m1_rvalid_o ? m1_data_o : m0_data_o) != mon_e.data || cyc != mon_e.cyc) begin
                    errors++;
                    $display("FAIL resp: got m%0d err=%0d data=%h cyc=%0d, required m%0d err=%0d data=%h cyc=%0d",
                             m1_rvalid_o, m1_rvalid_o ? m1_err_o : m0_err_o,
                             m1_rvalid_o ? m1_data_o : m0_data_o, cyc,
                             mon_e.m, mon_e.err, mon_e.data, mon_e.cyc);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, got, exp);
        end
    endtask

    task automatic drive(input bit m, input bit req, input logic [31:0] addr, input bit we, input logic [31:0] d);
        if (m) begin
            m1_req_i = req; m1_addr_i = addr; m1_we_i = we; m1_data_i = d; m1_sel_i = 4'hF;
        end else begin
            m0_req_i = req; m0_addr_i = addr; m0_we_i = we; m0_data_i = d; m0_sel_i = 4'hF;
        end
    endtask

    task automatic wait_gnt(output bit m, output int t);
        t = -1;
        m = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk_i);
            if (m0_gnt_o || m1_gnt_o) begin
                m = m1_gnt_o;
                t = cyc;
                return;
            end
        end
        checks++;
        errors++;
        $display("FAIL gnt_timeout: no grant within 50 cycles");
    endtask

    task automatic xact(input bit m, input logic [31:0] addr, input bit we, input logic [31:0] d,
                        input int l, input bit e_err, input logic [31:0] e_data, input bit want, output int t);
        bit gm;
        @(posedge clk_i); #1;
        drive(m, 1'b1, addr, we, d);
        wait_gnt(gm, t);
        chk("gnt_master", 32'(gm), 32'(m));
        if (want) q.push_back('{m, e_err, e_data, t + l});
        @(posedge clk_i); #1;
        drive(m, 1'b0, 32'h0, 1'b0, 32'h0);
    endtask

    task automatic drain();
        for (int i = 0; i < 60 && q.size() > 0; i++) @(negedge clk_i);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d responses still outstanding, required 0", q.size());
            q.delete();
        end
        repeat (2) @(negedge clk_i);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_gnt"}, 32'({m0_gnt_o, m1_gnt_o}), 32'h0);
        chk({tag, "_rvalid"}, 32'({m0_rvalid_o, m1_rvalid_o, m0_err_o, m1_err_o}), 32'h0);
        chk({tag, "_m0_data"}, m0_data_o, 32'h0);
        chk({tag, "_m1_data"}, m1_data_o, 32'h0);
        chk({tag, "_s_req"}, 32'(s_req_o), 32'h0);
        chk({tag, "_s_bus"}, 32'({s_sel_o, s_we_o}) | s_addr_o | s_data_o, 32'h0);
        chk({tag, "_err_cnt"}, 32'(err_cnt_o), 32'h0);
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit ord [3] = '{1'b0, 1'b1, 1'b0};
        int sp [3] = '{0, 4, 3};
        logic [15:0] sat [3] = '{16'hFFFE, 16'hFFFF, 16'hFFFF};
        bit gm;
        int t, tp;
        lat = '{0, 1, -1, 10, 2};
        for (int k = 0; k < NS; k++) begin
            cnt[k] = -1;
            s_data_i[32*k +: 32] = 32'hCAFE_0000 + 32'(k);
        end
        drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        drive(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
        n_rst_i = 1'b1;
        #1 n_rst_i = 1'b0;
        repeat (3) @(negedge clk_i);
        chk_all_zero("reset");
        @(posedge clk_i); #1 n_rst_i = 1'b1;

        // both masters contend out of reset: m0, m1, m0
        @(posedge clk_i); #1;
        drive(1'b0, 1'b1, 32'h1000_0008, 1'b0, 32'h0);
        drive(1'b1, 1'b1, 32'h0000_0000, 1'b0, 32'h0);
        tp = 0;
        for (int g = 0; g < 3; g++) begin
            wait_gnt(gm, t);
            chk("rr_order", 32'(gm), 32'(ord[g]));
            if (g > 0) chk("rr_spacing", 32'(t - tp), 32'(sp[g]));
            if (ord[g]) q.push_back('{1'b1, 1'b0, 32'hCAFE_0000, t + 2});
            else        q.push_back('{1'b0, 1'b0, 32'hCAFE_0001, t + 3});
            tp = t;
        end
        @(posedge clk_i); #1;
        drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        drive(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
        drain();

        // single-cycle slave read
        xact(1'b0, 32'h1000_0004, 1'b0, 32'h0, 3, 1'b0, 32'hCAFE_0001, 1'b1, t);
        @(negedge clk_i);
        chk("read_s_req", 32'(s_req_o), 32'h2);
        chk("read_s_addr", s_addr_o, 32'h1000_0004);
        @(negedge clk_i);
        chk("read_s_req_pulse", 32'(s_req_o), 32'h0);
        drain();

        // decode miss
        xact(1'b1, 32'h9000_0000, 1'b1, 32'h1234_5678, 1, 1'b1, 32'h0, 1'b1, t);
        @(negedge clk_i);
        chk("miss_no_s_req", 32'(s_req_o), 32'h0);
        chk("miss_latched_we", 32'(s_we_o), 32'h1);
        @(negedge clk_i);
        chk("miss_err_cnt", 32'(err_cnt_o), 32'h1);
        drain();

        // timeout with a late response that must be dropped
        lat[2] = 6;
        xact(1'b0, 32'h2000_0000, 1'b0, 32'h0, 6, 1'b1, 32'h0, 1'b1, t);
        @(negedge clk_i);
        chk("timeout_s_req", 32'(s_req_o), 32'h4);
        drain();
        repeat (6) @(negedge clk_i);
        chk("timeout_err_cnt", 32'(err_cnt_o), 32'h2);

        // asynchronous reset during a slow transaction
        xact(1'b0, 32'h3000_0000, 1'b0, 32'h0, 0, 1'b0, 32'h0, 1'b0, t);
        repeat (3) @(negedge clk_i);
        #2 n_rst_i = 1'b0;
        #1 chk_all_zero("async_reset");
        @(posedge clk_i);
        @(posedge clk_i); #1 n_rst_i = 1'b1;
        @(posedge clk_i); #1;
        drive(1'b0, 1'b1, 32'h0000_0010, 1'b0, 32'h0);
        drive(1'b1, 1'b1, 32'h0000_0020, 1'b0, 32'h0);
        wait_gnt(gm, t);
        chk("post_reset_gnt", 32'(gm), 32'h0);
        q.push_back('{1'b0, 1'b0, 32'hCAFE_0000, t + 2});
        tp = t;
        @(posedge clk_i); #1 drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        wait_gnt(gm, t);
        chk("post_reset_gnt2", 32'(gm), 32'h1);
        chk("post_reset_spacing", 32'(t - tp), 32'h3);
        q.push_back('{1'b1, 1'b0, 32'hCAFE_0000, t + 2});
        @(posedge clk_i); #1 drive(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
        drain();

        // error counter saturation
        force dut.r_err_cnt = 16'hFFFD;
        @(posedge clk_i); #1;
        release dut.r_err_cnt;
        for (int i = 0; i < 3; i++) begin
            xact(1'b1, 32'hF000_0000, 1'b0, 32'h0, 1, 1'b1, 32'h0, 1'b1, t);
            @(negedge clk_i);
            @(negedge clk_i);
            chk("err_cnt_sat", 32'(err_cnt_o), 32'(sat[i]));
        end
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
